// File: rtl/gate_resp_checker_pkg.sv
// Shared definitions for the CH01 gate checkers: FSM encoding, resp bit layout, failure record.
package gate_resp_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int RESP_W = 5;
  localparam int NAND_B = 4;
  localparam int NOT_B  = 3;
  localparam int AND_B  = 2;
  localparam int OR_B   = 1;
  localparam int XOR_B  = 0;

  typedef logic [RESP_W-1:0] resp_t;

  typedef struct packed {
    logic [1:0] vec;
    resp_t      mask;
  } fail_rec_t;

endpackage

// File: rtl/gate_expect.sv
// Ideal CH01 gate responses for one (a,b) input pair; purely combinational.
module gate_expect
  import gate_resp_checker_pkg::*;
(
  input  logic  a,
  input  logic  b,
  output resp_t expected
);

  always_comb begin
    expected         = '0;
    expected[NAND_B] = ~(a & b);
    expected[NOT_B]  = ~a;
    expected[AND_B]  = a & b;
    expected[OR_B]   = a | b;
    expected[XOR_B]  = a ^ b;
  end

endmodule

// File: rtl/gate_resp_checker.sv
// Sweeps {a,b} over 00..11 for NUM_PASSES passes, compares the five gate outputs
// to the ideal truth table and reports pass, saturating error count and first failure.
module gate_resp_checker
  import gate_resp_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  input  logic [4:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [4:0]       first_fail_mask
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_resp_checker: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_PASSES < 1) begin : g_bad_passes
    $error("gate_resp_checker: NUM_PASSES must be >= 1");
  end

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = $clog2(NUM_PASSES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t     state, next_state;
  logic       stim_on, sample_en, accept, finish;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    vec;
  logic [PW-1:0] pass_cnt;
  logic          settled, last_vec;
  resp_t         expected, mism;
  fail_rec_t     first_fail;

  gate_expect u_expect (
    .a        (vec[1]),
    .b        (vec[0]),
    .expected (expected)
  );

  // !== so that an X/Z response bit reads as a mismatch in simulation
  for (genvar i = 0; i < RESP_W; i++) begin : g_mism
    assign mism[i] = (resp[i] !== expected[i]);
  end

  assign settled  = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign last_vec = (vec == 2'b11) && (pass_cnt == PW'(NUM_PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start)    next_state = ST_DRIVE;
      ST_DRIVE:  if (settled)  next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = last_vec ? ST_DONE : ST_DRIVE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stim_on   = 1'b0;
    sample_en = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE:   accept = start;
      ST_DRIVE:  stim_on = 1'b1;
      ST_SAMPLE: begin stim_on = 1'b1; sample_en = 1'b1; end
      ST_DONE:   finish = 1'b1;
      default:   ;
    endcase
  end

  assign stim_a          = stim_on & vec[1];
  assign stim_b          = stim_on & vec[0];
  assign first_fail_vec  = first_fail.vec;
  assign first_fail_mask = first_fail.mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               settle_cnt <= '0;
    else if (state == ST_DRIVE && !settled)   settle_cnt <= settle_cnt + SW'(1);
    else                                      settle_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      pass_cnt   <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= finish;
      busy <= (next_state != ST_IDLE);
      if (accept) begin
        vec        <= '0;
        pass_cnt   <= '0;
        err_count  <= '0;
        first_fail <= '0;
        pass       <= 1'b0;
      end else if (sample_en) begin
        vec <= vec + 2'd1;
        if (vec == 2'b11) pass_cnt <= pass_cnt + PW'(1);
        if (|mism) begin
          if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          // a zero count means nothing has failed yet this sweep
          if (err_count == '0) begin
            first_fail.vec  <= vec;
            first_fail.mask <= mism;
          end
        end
      end
      if (finish) pass <= (err_count == '0);
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: two instances (default and ERR_W=2/NUM_PASSES=2) checked every cycle against a timeline model.
module tb_gate_resp_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  always #5 clk = ~clk;

  logic [1:0] sa, sb, bsy, dn, ps;
  logic [1:0] ffv0, ffv1;
  logic [4:0] ffm0, ffm1, rsp0, rsp1;
  logic [7:0] err0;
  logic [1:0] err1;
  int flt[2] = '{0, 3};
  int mj[2]  = '{-1, -1};
  int mflt[2] = '{0, 0};
  int cyc = 0;
  int ntotal = 0;
  int npass = 0;

  function automatic int tlen(input int idx);
    return 4 * ((idx == 0) ? 1 : 2) * (S + 1);
  endfunction
  function automatic int maxc(input int idx);
    return (idx == 0) ? 255 : 3;
  endfunction

  function automatic logic [4:0] ideal(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~(a & b), ~a, a & b, a | b, a ^ b};
  endfunction

  // fault modes: 0 healthy, 1 xor stuck 0, 2 not tied to a, 3 every output inverted
  function automatic logic [4:0] gate_model(input logic [1:0] v, input int f);
    logic [4:0] r;
    r = ideal(v);
    case (f)
      1: r[0] = 1'b0;
      2: r[3] = v[1];
      3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  task automatic sweep_result(input int f, input int k, input int mc,
                              output int err, output int fv, output int fm);
    logic [1:0] v;
    logic [4:0] m;
    err = 0; fv = 0; fm = 0;
    for (int i = 0; i < k; i++) begin
      v = 2'(i % 4);
      m = gate_model(v, f) ^ ideal(v);
      if (m != 5'd0) begin
        if (err == 0) begin fv = int'(v); fm = int'(m); end
        if (err < mc) err++;
      end
    end
  endtask

  always_comb begin
    rsp0 = gate_model({sa[0], sb[0]}, flt[0]);
    rsp1 = gate_model({sa[1], sb[1]}, flt[1]);
  end

  gate_resp_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stim_a(sa[0]), .stim_b(sb[0]),
    .resp(rsp0), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_mask(ffm0)
  );

  gate_resp_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stim_a(sa[1]), .stim_b(sb[1]),
    .resp(rsp1), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_mask(ffm1)
  );

  task automatic chk(input string name, input int idx, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s dut%0d: got %0d want %0d (t=%0t)", name, idx, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // model position: -1 never started, 0..T sweep in flight, T+1 done cycle, T+2 idle afterwards
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int idx = 0; idx < 2; idx++) mj[idx] <= -1;
    end else begin
      for (int idx = 0; idx < 2; idx++) begin
        if (mj[idx] >= 0 && mj[idx] < tlen(idx) + 1) mj[idx] <= mj[idx] + 1;
        else if (start[idx]) begin mj[idx] <= 0; mflt[idx] <= flt[idx]; end
        else if (mj[idx] >= 0) mj[idx] <= tlen(idx) + 2;
      end
    end
  end

  always @(negedge clk) begin
    for (int idx = 0; idx < 2; idx++) begin
      int j, t, v, k, e_err, e_fv, e_fm, a_err, a_fv, a_fm;
      j = mj[idx];
      t = tlen(idx);
      v = (j >= 0 && j < t) ? (j / (S + 1)) % 4 : 0;
      k = (j < 0) ? 0 : (((j / (S + 1)) < t / (S + 1)) ? j / (S + 1) : t / (S + 1));
      sweep_result(mflt[idx], k, maxc(idx), e_err, e_fv, e_fm);
      a_err = (idx == 0) ? int'(err0) : int'(err1);
      a_fv  = (idx == 0) ? int'(ffv0) : int'(ffv1);
      a_fm  = (idx == 0) ? int'(ffm0) : int'(ffm1);
      chk("stim_a", idx, int'(sa[idx]), (j >= 0 && j < t) ? (v >> 1) : 0);
      chk("stim_b", idx, int'(sb[idx]), (j >= 0 && j < t) ? (v & 1) : 0);
      chk("busy", idx, int'(bsy[idx]), (j >= 0 && j <= t) ? 1 : 0);
      chk("done", idx, int'(dn[idx]), (j == t + 1) ? 1 : 0);
      chk("pass", idx, int'(ps[idx]), (j >= t + 1 && e_err == 0) ? 1 : 0);
      chk("err_count", idx, a_err, e_err);
      chk("ff_vec", idx, a_fv, e_fv);
      chk("ff_mask", idx, a_fm, e_fm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pulse start, then wait (bounded) for done; optionally re-pulse start at cycles 4 and 12
  task automatic run_sweep(input int idx, input int f, input bit extra, output int lat, output int ndone);
    int c0;
    bit seen;
    flt[idx] = f;
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    c0 = cyc;
    lat = -1; ndone = 0; seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      start[idx] = extra && ((cyc - c0) == 4 || (cyc - c0) == 12);
      if (dn[idx]) begin ndone++; lat = cyc - c0; seen = 1; end
    end
    start[idx] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (dn[idx]) ndone++;
    end
    chk("sweep_timeout", idx, int'(seen), 1);
  endtask

  initial begin
    int lat, nd, c0;
    repeat (3) tick();
    chk("rst_busy", 0, int'(bsy[0]), 0);
    chk("rst_err", 0, int'(err0), 0);
    chk("rst_stim", 0, int'({sa[0], sb[0]}), 0);
    rst_n = 1'b1;
    tick();

    // healthy gates
    run_sweep(0, 0, 1'b0, lat, nd);
    chk("t1_latency", 0, lat, 13);
    chk("t1_pass", 0, int'(ps[0]), 1);
    chk("t1_err", 0, int'(err0), 0);

    // xor stuck at 0
    run_sweep(0, 1, 1'b0, lat, nd);
    chk("t2_err", 0, int'(err0), 2);
    chk("t2_ffv", 0, int'(ffv0), 1);
    chk("t2_ffm", 0, int'(ffm0), 5'b00001);
    chk("t2_pass", 0, int'(ps[0]), 0);

    // not tied to a
    run_sweep(0, 2, 1'b0, lat, nd);
    chk("t3_err", 0, int'(err0), 4);
    chk("t3_ffv", 0, int'(ffv0), 0);
    chk("t3_ffm", 0, int'(ffm0), 5'b01000);

    // extra start pulses while busy / in DONE
    run_sweep(0, 1, 1'b1, lat, nd);
    chk("t4_ndone", 0, nd, 1);
    chk("t4_err", 0, int'(err0), 2);
    chk("t4_latency", 0, lat, 13);

    // reset mid-sweep, then a clean sweep
    flt[0] = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    c0 = cyc;
    while (cyc - c0 < 6) tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("t5_rst_busy", 0, int'(bsy[0]), 0);
    chk("t5_rst_stim", 0, int'({sa[0], sb[0]}), 0);
    rst_n = 1'b1;
    tick();
    run_sweep(0, 0, 1'b0, lat, nd);
    chk("t5_latency", 0, lat, 13);
    chk("t5_pass", 0, int'(ps[0]), 1);

    // start held high: back-to-back sweeps
    flt[0] = 1;
    start[0] = 1'b1;
    nd = 0;
    for (int n = 0; n < 28; n++) begin
      tick();
      if (dn[0]) nd++;
    end
    start[0] = 1'b0;
    chk("held_ndone", 0, nd, 2);
    for (int n = 0; n < 40 && bsy[0]; n++) tick();
    chk("held_idle", 0, int'(bsy[0]), 0);
    tick();
    tick();

    // saturation: ERR_W=2, two passes, all outputs wrong
    run_sweep(1, 3, 1'b0, lat, nd);
    chk("t6_latency", 1, lat, 25);
    chk("t6_err", 1, int'(err1), 3);
    chk("t6_pass", 1, int'(ps[1]), 0);
    chk("t6_ffm", 1, int'(ffm1), 5'b11111);

    tick();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
